// File: rtl/rgb_fade_seq_if.sv
// Host-side target-colour handshake for rgb_fade_seq.
interface rgb_fade_seq_if;
    logic        tgt_valid;
    logic        tgt_ready;
    logic [23:0] tgt_rgb;

    modport master (
        output tgt_valid,
        output tgt_rgb,
        input  tgt_ready
    );

    modport slave (
        input  tgt_valid,
        input  tgt_rgb,
        output tgt_ready
    );
endinterface

// File: rtl/rgb_fade_seq.sv
// Colour-fade sequencer with three-channel PWM output for SB_RGBA_DRV.
// A loaded 24-bit target is approached one LSB per fade step on each channel, held for
// HOLD_STEPS steps, then the block idles with the colour kept. Duty is only updated at
// the PWM period boundary so no truncated pulses reach the LEDs.
// rst asserts asynchronously; its release must already be synchronous to clki.
module rgb_fade_seq #(
    parameter int unsigned PRESCALE   = 600000,
    parameter int unsigned HOLD_STEPS = 64
) (
    input  logic          clki,
    input  logic          rst,
    rgb_fade_seq_if.slave host,
    output logic          busy,
    output logic          pwm_red,
    output logic          pwm_green,
    output logic          pwm_blue
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [PW-1:0] PresLast = PW'(PRESCALE - 1);
    localparam logic [HW-1:0] HoldLast = HW'(HOLD_STEPS - 1);

    typedef enum logic [1:0] {StIdle, StFade, StHold} state_e;

    state_e        r_state;
    state_e        w_state_d;
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_d;
    logic [PW-1:0] r_presc;
    logic [7:0]    r_pwm_cnt;
    logic [7:0]    r_cur [3];
    logic [7:0]    r_tgt [3];
    logic [7:0]    r_act [3];
    logic [2:0]    r_pwm;

    logic w_step_tick;
    logic w_ready;
    logic w_xfer;
    logic w_all_eq;
    logic w_load;
    logic w_step;

    assign w_step_tick    = (r_presc == PresLast);
    assign w_ready        = (r_state != StFade);
    assign w_xfer         = host.tgt_valid && w_ready;
    assign w_all_eq       = (r_cur[0] == r_tgt[0]) && (r_cur[1] == r_tgt[1]) &&
                            (r_cur[2] == r_tgt[2]);
    assign host.tgt_ready = w_ready;
    assign busy           = (r_state != StIdle);
    assign pwm_red        = r_pwm[0];
    assign pwm_green      = r_pwm[1];
    assign pwm_blue       = r_pwm[2];

    // Free-running fade-step prescaler, runs in every state.
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_step_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // PWM counter, period-aligned duty capture and registered compare outputs.
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            r_pwm_cnt <= '0;
            r_pwm     <= '0;
            for (int i = 0; i < 3; i++) begin
                r_act[i] <= '0;
            end
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            for (int i = 0; i < 3; i++) begin
                r_pwm[i] <= (r_pwm_cnt < r_act[i]);
                if (r_pwm_cnt == 8'hFF) begin
                    r_act[i] <= r_cur[i];
                end
            end
        end
    end

    // FSM state and hold counter registers.
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_d;
            r_hold  <= w_hold_d;
        end
    end

    // Next-state decode; a transfer in HOLD takes priority over a same-cycle tick.
    always_comb begin
        w_state_d = r_state;
        w_hold_d  = r_hold;
        w_load    = 1'b0;
        w_step    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_xfer) begin
                    w_state_d = StFade;
                    w_load    = 1'b1;
                end
            end
            StFade: begin
                if (w_all_eq) begin
                    w_state_d = StHold;
                    w_hold_d  = '0;
                end else if (w_step_tick) begin
                    w_step = 1'b1;
                end
            end
            StHold: begin
                if (w_xfer) begin
                    w_state_d = StFade;
                    w_load    = 1'b1;
                    w_hold_d  = '0;
                end else if (w_step_tick) begin
                    if (r_hold == HoldLast) begin
                        w_state_d = StIdle;
                    end else begin
                        w_hold_d = r_hold + 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Target latch and per-channel one-LSB step toward the target (never overshoots).
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                r_cur[i] <= '0;
                r_tgt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_load) begin
                    r_tgt[i] <= host.tgt_rgb[8*(2-i) +: 8];
                end
                if (w_step) begin
                    if (r_cur[i] < r_tgt[i]) begin
                        r_cur[i] <= r_cur[i] + 8'd1;
                    end else if (r_cur[i] > r_tgt[i]) begin
                        r_cur[i] <= r_cur[i] - 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rgb_fade_seq.sv
// Self-checking bench for rgb_fade_seq: a behavioural colour-fade model is compared
// against the DUT outputs every cycle, plus directed scenario checks.
module tb_rgb_fade_seq;

    localparam int unsigned PS = 4;
    localparam int unsigned HS = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic pwm_red;
    logic pwm_green;
    logic pwm_blue;
    bit   chk_en = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    rgb_fade_seq_if bus ();

    rgb_fade_seq #(
        .PRESCALE   (PS),
        .HOLD_STEPS (HS)
    ) u_dut (
        .clki      (clk),
        .rst       (rst),
        .host      (bus.slave),
        .busy      (busy),
        .pwm_red   (pwm_red),
        .pwm_green (pwm_green),
        .pwm_blue  (pwm_blue)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 fading, 2 holding.
    int m_phase;
    int m_cur [3];
    int m_tgt [3];
    int m_act [3];
    int m_pwm [3];
    int m_presc;
    int m_pcnt;
    int m_hold;

    always @(posedge clk or posedge rst) begin
        bit tick;
        bit xfer;
        bit same;
        if (rst) begin
            m_phase = 0;
            m_presc = 0;
            m_pcnt  = 0;
            m_hold  = 0;
            for (int i = 0; i < 3; i++) begin
                m_cur[i] = 0; m_tgt[i] = 0; m_act[i] = 0; m_pwm[i] = 0;
            end
        end else begin
            tick = (m_presc == PS - 1);
            xfer = bus.tgt_valid && (m_phase != 1);
            for (int i = 0; i < 3; i++) begin
                m_pwm[i] = (m_pcnt < m_act[i]) ? 1 : 0;
                if (m_pcnt == 255) m_act[i] = m_cur[i];
            end
            m_pcnt  = (m_pcnt + 1) % 256;
            m_presc = (m_presc + 1) % PS;
            same = 1'b1;
            for (int i = 0; i < 3; i++) if (m_cur[i] != m_tgt[i]) same = 1'b0;
            if (m_phase == 0) begin
                if (xfer) begin
                    for (int i = 0; i < 3; i++) m_tgt[i] = (bus.tgt_rgb >> (8 * (2 - i))) & 255;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (same) begin
                    m_phase = 2;
                    m_hold  = 0;
                end else if (tick) begin
                    for (int i = 0; i < 3; i++) begin
                        if (m_tgt[i] > m_cur[i]) m_cur[i] = m_cur[i] + 1;
                        else if (m_tgt[i] < m_cur[i]) m_cur[i] = m_cur[i] - 1;
                    end
                end
            end else begin
                if (xfer) begin
                    for (int i = 0; i < 3; i++) m_tgt[i] = (bus.tgt_rgb >> (8 * (2 - i))) & 255;
                    m_phase = 1;
                    m_hold  = 0;
                end else if (tick) begin
                    if (m_hold + 1 >= HS) m_phase = 0;
                    else m_hold = m_hold + 1;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            check_eq("outs", {27'd0, pwm_red, pwm_green, pwm_blue, busy, bus.tgt_ready},
                     {27'd0, m_pwm[0][0], m_pwm[1][0], m_pwm[2][0], m_phase != 0, m_phase != 1});
        end
    end

    task automatic send(input logic [23:0] rgb);
        @(negedge clk);
        bus.tgt_valid = 1'b1;
        bus.tgt_rgb   = rgb;
        @(negedge clk);
        bus.tgt_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy !== 1'b0 || m_phase != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    task automatic count_high(input int ch, input int cycles, output int hi);
        hi = 0;
        repeat (cycles) begin
            @(negedge clk);
            #1;
            if ((ch == 0 && pwm_red) || (ch == 1 && pwm_green) || (ch == 2 && pwm_blue)) hi++;
        end
    endtask

    initial begin
        int cnt;
        int n;
        int k;
        bus.tgt_valid = 1'b0;
        bus.tgt_rgb   = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Quiet after reset.
        cnt = 0;
        repeat (1024) begin
            @(negedge clk);
            #1;
            if (pwm_red || pwm_green || pwm_blue) cnt++;
        end
        check_eq("reset_pwm_quiet", cnt, 0);
        check_eq("reset_ready", {31'd0, bus.tgt_ready}, 32'd1);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);

        // Small red fade, then measure duty.
        send(24'h030000);
        wait_idle(200);
        repeat (256) @(negedge clk);
        count_high(0, 256, cnt);
        check_eq("red_duty_3", cnt, 3);
        count_high(1, 256, cnt);
        check_eq("green_duty_0", cnt, 0);

        // Short two-step fade with opposite directions.
        send(24'hFF0080);
        wait_idle(2000);
        send(24'hFE0082);
        n = 0;
        while (busy && !bus.tgt_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("fade2_len_ok", {31'd0, (n >= PS + 2 && n <= 2 * PS + 1)}, 32'd1);
        wait_idle(200);

        // Valid during FADE is ignored; transfer in HOLD on a tick restarts the fade.
        send(24'h101010);
        repeat (5) @(negedge clk);
        check_eq("fade_not_ready", {31'd0, bus.tgt_ready}, 32'd0);
        send(24'h00FF00);
        n = 0;
        while (m_phase != 2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("reached_hold", m_phase, 2);
        n = 0;
        while (m_presc != PS - 1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        bus.tgt_valid = 1'b1;
        bus.tgt_rgb   = 24'h102030;
        @(negedge clk);
        bus.tgt_valid = 1'b0;
        #1;
        check_eq("hold_tick_xfer_fade", {30'd0, busy, bus.tgt_ready}, 32'd2);
        wait_idle(2000);

        // Duty change requested mid-period, then full-scale green.
        n = 0;
        while (m_pcnt != 100 && n < 300) begin
            @(negedge clk);
            n++;
        end
        bus.tgt_valid = 1'b1;
        bus.tgt_rgb   = 24'h102031;
        @(negedge clk);
        bus.tgt_valid = 1'b0;
        wait_idle(200);
        send(24'h00FF00);
        wait_idle(2000);
        repeat (256) @(negedge clk);
        count_high(1, 256, cnt);
        check_eq("green_one_low", cnt, 255);
        count_high(0, 256, cnt);
        check_eq("red_off", cnt, 0);

        // Reset in the middle of a fade.
        send(24'h800000);
        n = 0;
        while (m_cur[0] != 8'h40 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        #1;
        check_eq("rst_pwm", {29'd0, pwm_red, pwm_green, pwm_blue}, 32'd0);
        check_eq("rst_ready_busy", {30'd0, busy, bus.tgt_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Randomized targets with random extra valid pulses.
        for (int it = 0; it < 8; it++) begin
            send(24'($urandom));
            k = $urandom_range(0, 200);
            repeat (k) begin
                @(negedge clk);
                bus.tgt_valid = ($urandom_range(0, 7) == 0);
                bus.tgt_rgb   = 24'($urandom);
            end
            @(negedge clk);
            bus.tgt_valid = 1'b0;
            wait_idle(3000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
